// File: rtl/pipe_stage_skid.sv
// -----------------------------------------------------------------------------
// pipe_stage_skid
//   Generic pipeline stage register with a valid/ready handshake. It replaces
//   the fixed IF/ID, ID/EXE, EXE/MEM and MEM/WB registers. It carries an opaque
//   DATA_W-bit payload, such as packed control bits, ALU result, store data
//   and destination register.
//
//   SKID=1 : two entries, made of a main (output) register and a skid
//            (overflow) register.
//            - in_ready is a pure function of state, so no combinational path
//              runs from out_ready to in_ready.
//            - Back-pressure from a slow consumer costs no bubbles.
//   SKID=0 : one register only.
//            - in_ready = !out_valid | out_ready, which allows a pass-through
//              refill in the same cycle as an issue.
//
//   out_valid and out_data come from flops; no combinational path runs from
//   input to output. flush empties the stage. The payload flops keep their
//   stale contents.
//
// Ports
//   clk        in   1       rising-edge clock
//   clr        in   1       synchronous active-high reset (overrides everything)
//   flush      in   1       drop all held entries and any payload offered now
//   in_valid   in   1       upstream payload valid
//   in_ready   out  1       stage can accept this cycle
//   in_data    in   DATA_W  upstream payload
//   out_valid  out  1       out_data valid for downstream
//   out_ready  in   1       downstream accepts this cycle
//   out_data   out  DATA_W  payload to downstream
//   occupancy  out  2       entries held (0..2, at most 1 when SKID=0)
// -----------------------------------------------------------------------------
module pipe_stage_skid #(
  parameter int unsigned       DATA_W  = 32,
  parameter int unsigned       SKID    = 1,
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  // The encoding equals the entry count, so occupancy is taken directly
  // from the state flops.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b10
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              accept;
  logic              issue;

  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q;
  assign occupancy = state_q;

  always_comb begin
    if (SKID != 0) begin
      in_ready = (state_q != FULL);
    end else begin
      in_ready = !out_valid || out_ready;
    end
  end

  assign accept = in_valid && in_ready;
  assign issue  = out_valid && out_ready;

  // Payload registers load only on accept. in_data is therefore never
  // sampled while in_valid is low.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            main_d  = in_data;
            state_d = ONE;
          end
        end
        ONE: begin
          if (accept && issue) begin
            main_d = in_data;
          end else if (accept && (SKID != 0)) begin
            skid_d  = in_data;
            state_d = FULL;
          end else if (issue) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (issue) begin
            main_d  = skid_q;
            state_d = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= EMPTY;
      main_q  <= RST_VAL;
      skid_q  <= RST_VAL;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

`ifndef SYNTHESIS
  // A stalled output must stay valid and keep its data stable.
  a_hold_stable: assert property (@(posedge clk) disable iff (clr)
    (out_valid && !out_ready && !flush) |=> (out_valid && $stable(out_data)));

  // The single-register build never holds a second entry.
  a_no_full_single: assert property (@(posedge clk) disable iff (clr)
    (SKID == 0) |-> (state_q != FULL));
`endif

endmodule
